// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the gate-time frequency meter.
// The meter counts edges of an asynchronous input over a fixed window of Clk_50M cycles.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GATE  = 2'd1,
        ST_LATCH = 2'd2
    } fm_state_e;

    localparam int unsigned CLK_HZ    = 50_000_000;
    localparam int unsigned GATE_1S   = 50_000_000;
    localparam int unsigned CNT_W_DEF = 27;

    // The gate down-counter holds GATE_CYCLES-1 at most, so it needs clog2(GATE_CYCLES) bits.
    function automatic int unsigned gate_cnt_w(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/freq_meter_if.sv
// Control and result bundle of the frequency meter.
// The meter is the slave; the requester or readout side is the master.
interface freq_meter_if
    import freq_meter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             sig_in;
    logic             start;
    logic             cont;
    logic [CNT_W-1:0] freq;
    logic             valid;
    logic             busy;
    logic             ovf;

    modport master (
        output sig_in, start, cont,
        input  freq, valid, busy, ovf
    );

    modport slave (
        input  sig_in, start, cont,
        output freq, valid, busy, ovf
    );
endinterface

// File: rtl/freq_meter_sync_edge_det.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// Usable for any asynchronous level such as buttons or external clocks.
module sync_edge_det (
    input  logic Clk_50M,
    input  logic Rst,
    input  logic async_in,
    output logic edge_pulse
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    // A rise sampled at edge k shows up as edge_pulse in the cycle after edge k+2.
    always_ff @(posedge Clk_50M or posedge Rst) begin
        if (Rst) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            prev_q     <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            meta_q     <= async_in;
            sync_q     <= meta_q;
            prev_q     <= sync_q;
            edge_pulse <= sync_q & ~prev_q;
        end
    end
endmodule

// File: rtl/freq_meter.sv
// Gate-time frequency meter: counts synchronized rising edges of sig_in over
// GATE_CYCLES clocks and latches the (saturating) count into freq.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start or cont; counters hold
// ST_GATE  | window open, edges counted for exactly GATE_CYCLES cycles
// ST_LATCH | result presented (valid high); edges in this cycle dropped
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = GATE_1S,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic        Clk_50M,
    input  logic        Rst,
    freq_meter_if.slave bus
);
    localparam int unsigned    GW        = gate_cnt_w(GATE_CYCLES);
    localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fm_state_e        state_q;
    fm_state_e        state_d;
    logic [GW-1:0]    gate_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sat_q;
    logic             sat_nxt;
    logic             edge_p;
    logic             gate_tc;
    logic             win_open;
    logic             win_close;
    logic [CNT_W-1:0] freq_q;
    logic             valid_q;
    logic             ovf_q;

    sync_edge_det u_sync (
        .Clk_50M    (Clk_50M),
        .Rst        (Rst),
        .async_in   (bus.sig_in),
        .edge_pulse (edge_p)
    );

    assign gate_tc = (gate_q == '0);

    always_ff @(posedge Clk_50M or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start is only looked at in IDLE, so requests during a window are simply lost.
    always_comb begin
        state_d   = state_q;
        win_open  = 1'b0;
        win_close = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start || bus.cont) begin
                    state_d  = ST_GATE;
                    win_open = 1'b1;
                end
            end
            ST_GATE: begin
                if (gate_tc) begin
                    state_d   = ST_LATCH;
                    win_close = 1'b1;
                end
            end
            ST_LATCH: begin
                if (bus.cont) begin
                    state_d  = ST_GATE;
                    win_open = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt = cnt_q;
        sat_nxt = sat_q;
        if (edge_p) begin
            if (cnt_q == CNT_MAX) begin
                sat_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk_50M or posedge Rst) begin
        if (Rst) begin
            gate_q <= '0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else if (win_open) begin
            gate_q <= GATE_LAST;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else if (state_q == ST_GATE) begin
            cnt_q <= cnt_nxt;
            sat_q <= sat_nxt;
            if (!gate_tc) begin
                gate_q <= gate_q - GW'(1);
            end
        end
    end

    // Latching cnt_nxt rather than cnt_q keeps an edge in the final gate cycle.
    always_ff @(posedge Clk_50M or posedge Rst) begin
        if (Rst) begin
            freq_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= win_close;
            if (win_close) begin
                freq_q <= cnt_nxt;
                ovf_q  <= sat_nxt;
            end
        end
    end

    assign bus.freq  = freq_q;
    assign bus.valid = valid_q;
    assign bus.ovf   = ovf_q;
    assign bus.busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (27-bit and 4-bit counters) share stimulus and
// are compared every cycle against a window/edge-time model, plus literal expectations.
module tb_freq_meter;

    localparam int    G     = 1000;
    localparam longint MAX_A = (64'd1 << 27) - 1;
    localparam longint MAX_B = 15;

    logic Clk_50M = 1'b0;
    logic Rst     = 1'b0;
    logic sig_drv = 1'b0;
    logic start_drv = 1'b0;
    logic cont_drv  = 1'b0;

    freq_meter_if #(.CNT_W(27)) bus_a ();
    freq_meter_if #(.CNT_W(4))  bus_b ();

    assign bus_a.sig_in = sig_drv;
    assign bus_a.start  = start_drv;
    assign bus_a.cont   = cont_drv;
    assign bus_b.sig_in = sig_drv;
    assign bus_b.start  = start_drv;
    assign bus_b.cont   = cont_drv;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(27)) dut_a (
        .Clk_50M (Clk_50M),
        .Rst     (Rst),
        .bus     (bus_a)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut_b (
        .Clk_50M (Clk_50M),
        .Rst     (Rst),
        .bus     (bus_b)
    );

    always #10 Clk_50M = ~Clk_50M;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Model: a rise first sampled at edge k is counted at edge k+3; a window started
    // at edge S counts edges S+1..S+G, presents the result after S+G, frees at S+G+1.
    longint n_cyc = 0;
    longint win_s = 0;
    longint cnt   = 0;
    bit     active = 1'b0;
    bit     prev_sig = 1'b0;
    longint pend[$];
    bit     exp_valid = 1'b0;
    bit     exp_busy  = 1'b0;
    bit     exp_ovf_a = 1'b0;
    bit     exp_ovf_b = 1'b0;
    longint exp_freq_a = 0;
    longint exp_freq_b = 0;

    always @(posedge Clk_50M or posedge Rst) begin
        if (Rst) begin
            active     = 1'b0;
            prev_sig   = 1'b0;
            cnt        = 0;
            pend.delete();
            exp_valid  = 1'b0;
            exp_busy   = 1'b0;
            exp_ovf_a  = 1'b0;
            exp_ovf_b  = 1'b0;
            exp_freq_a = 0;
            exp_freq_b = 0;
        end else begin
            bit edge_now;
            n_cyc++;
            edge_now = 1'b0;
            if (pend.size() > 0 && pend[0] == n_cyc) begin
                edge_now = 1'b1;
                void'(pend.pop_front());
            end
            if (sig_drv && !prev_sig) pend.push_back(n_cyc + 3);
            prev_sig  = sig_drv;
            exp_valid = 1'b0;
            if (active) begin
                if (edge_now && n_cyc >= win_s + 1 && n_cyc <= win_s + G) cnt++;
                if (n_cyc == win_s + G) begin
                    exp_valid  = 1'b1;
                    exp_freq_a = (cnt > MAX_A) ? MAX_A : cnt;
                    exp_ovf_a  = (cnt > MAX_A);
                    exp_freq_b = (cnt > MAX_B) ? MAX_B : cnt;
                    exp_ovf_b  = (cnt > MAX_B);
                end else if (n_cyc == win_s + G + 1) begin
                    active = 1'b0;
                    if (cont_drv) begin
                        active = 1'b1;
                        win_s  = n_cyc;
                        cnt    = 0;
                    end
                end
            end else if (start_drv || cont_drv) begin
                active = 1'b1;
                win_s  = n_cyc;
                cnt    = 0;
            end
            exp_busy = active;
        end
    end

    bit chk_en    = 1'b0;
    int valid_cnt = 0;

    always @(negedge Clk_50M) begin
        if (chk_en && !Rst) begin
            chk("valid_a", bus_a.valid, exp_valid);
            chk("busy_a",  bus_a.busy,  exp_busy);
            chk("freq_a",  bus_a.freq,  exp_freq_a);
            chk("ovf_a",   bus_a.ovf,   exp_ovf_a);
            chk("valid_b", bus_b.valid, exp_valid);
            chk("busy_b",  bus_b.busy,  exp_busy);
            chk("freq_b",  bus_b.freq,  exp_freq_b);
            chk("ovf_b",   bus_b.ovf,   exp_ovf_b);
            if (bus_a.valid) valid_cnt++;
        end
    end

    // sig_in source: 0 = low, 1 = high, 2 = periodic (first half of period high)
    int sig_mode = 0;
    int sig_per  = 10;
    int ph       = 0;

    initial begin
        forever begin
            @(negedge Clk_50M);
            case (sig_mode)
                0:       sig_drv = 1'b0;
                1:       sig_drv = 1'b1;
                default: begin
                    ph      = (ph + 1) % sig_per;
                    sig_drv = (ph < sig_per / 2);
                end
            endcase
        end
    end

    task automatic set_sig(input int m, input int p);
        sig_mode = m;
        sig_per  = p;
        ph       = 0;
    endtask

    task automatic pulse_start(output longint se);
        @(negedge Clk_50M);
        start_drv = 1'b1;
        @(negedge Clk_50M);
        start_drv = 1'b0;
        se = n_cyc;
    endtask

    task automatic wait_valid(input string nm, output longint at);
        bit seen;
        seen = 1'b0;
        at   = -1;
        for (int i = 0; i < G + 100 && !seen; i++) begin
            @(negedge Clk_50M);
            if (bus_a.valid === 1'b1) begin
                seen = 1'b1;
                at   = n_cyc;
            end
        end
        chk(nm, seen, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint se, at, t1, t2, t3, dummy;
        int vc;

        // 1: reset with sig_in toggling
        set_sig(2, 4);
        #1 Rst = 1'b1;
        repeat (5) @(negedge Clk_50M);
        chk("rst_freq",  bus_a.freq,  0);
        chk("rst_valid", bus_a.valid, 0);
        chk("rst_busy",  bus_a.busy,  0);
        chk("rst_ovf",   bus_a.ovf,   0);
        chk("rst_freq_b", bus_b.freq, 0);
        Rst    = 1'b0;
        chk_en = 1'b1;
        repeat (50) @(negedge Clk_50M);
        chk("idle_no_valid", valid_cnt, 0);
        chk("idle_busy", bus_a.busy, 0);

        // 2: single measurement, period 10
        set_sig(2, 10);
        repeat (30) @(negedge Clk_50M);
        vc = valid_cnt;
        pulse_start(se);
        wait_valid("s2_valid", at);
        chk("s2_latency", at - se, G);
        chk("s2_freq", bus_a.freq, 100);
        chk("s2_ovf",  bus_a.ovf,  0);
        repeat (20) @(negedge Clk_50M);
        chk("s2_one_valid", valid_cnt - vc, 1);
        repeat ($urandom_range(1, 9)) @(negedge Clk_50M);
        pulse_start(se);
        wait_valid("s2r_valid", at);
        chk("s2r_range", (bus_a.freq >= 99 && bus_a.freq <= 101), 1);

        // 3: continuous mode, period 20, cont dropped mid-window
        set_sig(2, 20);
        repeat (40) @(negedge Clk_50M);
        cont_drv = 1'b1;
        wait_valid("s3_v1", t1);
        chk("s3_freq1", bus_a.freq, 50);
        wait_valid("s3_v2", t2);
        chk("s3_space12", t2 - t1, G + 1);
        chk("s3_freq2", bus_a.freq, 50);
        repeat (300) @(negedge Clk_50M);
        cont_drv = 1'b0;
        wait_valid("s3_v3", t3);
        chk("s3_space23", t3 - t2, G + 1);
        chk("s3_freq3", bus_a.freq, 50);
        repeat (2) @(negedge Clk_50M);
        chk("s3_busy_fall", bus_a.busy, 0);
        vc = valid_cnt;
        repeat (1100) @(negedge Clk_50M);
        chk("s3_idle_held", valid_cnt - vc, 0);

        // 4: 4-bit counter saturates, then recovers with quiet input
        set_sig(2, 10);
        repeat (20) @(negedge Clk_50M);
        pulse_start(se);
        wait_valid("s4_valid", at);
        chk("s4_freq_b", bus_b.freq, 15);
        chk("s4_ovf_b",  bus_b.ovf,  1);
        chk("s4_freq_a", bus_a.freq, 100);
        set_sig(0, 10);
        repeat (10) @(negedge Clk_50M);
        pulse_start(se);
        wait_valid("s4q_valid", at);
        chk("s4q_freq_b", bus_b.freq, 0);
        chk("s4q_ovf_b",  bus_b.ovf,  0);

        // 5: extra starts ignored; reset mid-window
        set_sig(2, 10);
        repeat (20) @(negedge Clk_50M);
        vc = valid_cnt;
        pulse_start(se);
        repeat (100) @(negedge Clk_50M);
        pulse_start(dummy);
        repeat (200) @(negedge Clk_50M);
        pulse_start(dummy);
        wait_valid("s5_valid", at);
        repeat (1100) @(negedge Clk_50M);
        chk("s5_one_valid", valid_cnt - vc, 1);
        pulse_start(se);
        repeat (499) @(negedge Clk_50M);
        chk("s5_busy_pre", bus_a.busy, 1);
        chk("s5_freq_pre", bus_a.freq, 100);
        #3 Rst = 1'b1;
        #1;
        chk("s5_rst_freq",  bus_a.freq,  0);
        chk("s5_rst_busy",  bus_a.busy,  0);
        chk("s5_rst_valid", bus_a.valid, 0);
        chk("s5_rst_ovf",   bus_a.ovf,   0);
        chk("s5_rst_freq_b", bus_b.freq, 0);
        repeat (3) @(negedge Clk_50M);
        Rst = 1'b0;
        vc  = valid_cnt;
        repeat (1100) @(negedge Clk_50M);
        chk("s5_no_valid", valid_cnt - vc, 0);

        // 6: constant inputs, then 1-cycle toggling (aliasing, only must not hang)
        set_sig(1, 10);
        repeat (10) @(negedge Clk_50M);
        pulse_start(se);
        wait_valid("s6h_valid", at);
        chk("s6h_freq", bus_a.freq, 0);
        set_sig(0, 10);
        repeat (10) @(negedge Clk_50M);
        pulse_start(se);
        wait_valid("s6l_valid", at);
        chk("s6l_freq", bus_a.freq, 0);
        set_sig(2, 2);
        repeat (5) @(negedge Clk_50M);
        pulse_start(se);
        wait_valid("s6a_no_hang", at);

        repeat (5) @(negedge Clk_50M);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gate-time frequency meter for the 50 MHz board clock domain. It counts rising edges of an asynchronous input, such as one of the divided 1 Hz / 1 kHz / 5 kHz clocks or an external pin, over a programmable gate window of `Clk_50M` cycles. At the end of each window it latches the count as the measured frequency. It checks the clock-generator outputs on hardware and feeds the display/readout logic.

## Interface
- `GATE_CYCLES`, default 50_000_000: gate window length in `Clk_50M` cycles (1 s gate gives a result in Hz); legal range ≥ 2.
- `CNT_W`, default 27: width of the edge counter and of `freq`.
- `Clk_50M`  in  1  system clock, 50 MHz. One clock; reset is asynchronous and active-high.
- `Rst`  in  1  asynchronous, active-high reset.
- `sig_in`  in  1  asynchronous signal under measurement.
- `start`  in  1  single-cycle request for one measurement; sampled only in IDLE.
- `cont`  in  1  continuous mode level; while high, windows repeat back-to-back.
- `freq`  out  CNT_W  last latched edge count.
- `valid`  out  1  one-cycle pulse when `freq` updates.
- `busy`  out  1  high in GATE and LATCH.
- `ovf`  out  1  last latched window saturated.

## Operation
- `sig_in` passes through a 2-FF synchronizer and a rising-edge detector. `edge` is high for one cycle per rising edge of `sig_in`.
- The FSM has three states: IDLE, GATE, LATCH.
- IDLE goes to GATE when `start` or `cont` is high. The edge counter and the gate counter clear on entry.
- GATE counts `edge` pulses and lasts exactly `GATE_CYCLES` cycles. An edge pulse in the last GATE cycle is counted. After the last cycle the FSM goes to LATCH.
- LATCH:
  - `freq` is loaded with the count, `ovf` with the saturate flag, and `valid` is 1 for this cycle.
  - Next state is GATE if `cont` is high, else IDLE.
  - Edges arriving during the LATCH cycle are dropped.
- The edge counter saturates at all-ones and sets an internal sticky flag for the window. It never wraps.
- `start` in GATE or LATCH is ignored and not queued.
- Deasserting `cont` mid-window lets the current window complete and latch, then returns to IDLE.
- Simultaneous `start` and `cont` is treated as one request.

## Timing
- Reset values: `freq` = 0, `valid` = 0, `busy` = 0, `ovf` = 0, FSM = IDLE, all counters and synchronizer flops 0.
- Reset mid-window aborts immediately. No `valid` is produced and the previous `freq` is cleared to 0.
- Request latency: `start` high in IDLE at cycle t gives GATE for cycles t+1 … t+GATE_CYCLES and LATCH at t+GATE_CYCLES+1. `freq`, `ovf` and `valid` are registered and change at that edge.
- Continuous spacing: `valid` pulses exactly GATE_CYCLES+1 cycles apart.
- Input latency: a `sig_in` rising edge produces `edge` 3 `Clk_50M` cycles later.
- Minimum measurable input: high and low phases each ≥ 2 `Clk_50M` periods, so max about 12.5 MHz. Faster inputs are undercounted (aliasing), which is not flagged.
- Synchronizer flops reset to 0. If `sig_in` is high at reset release and a window starts within 3 cycles, one extra edge is counted. This is an accepted artifact.
- Accuracy: ±1 count from the phase of `sig_in` relative to the gate.
- `busy` is high in GATE and LATCH and low in IDLE.

## Structure
- `freq_meter_pkg` holds:
  - the FSM state encoding (IDLE, GATE, LATCH);
  - default constants: `CLK_HZ` = 50_000_000, `GATE_1S` = 50_000_000, `CNT_W_DEF` = 27.
- Sub-module `sync_edge_det`: 2-FF synchronizer plus rising-edge pulse, async active-high reset. It is reusable for buttons and other async inputs.
- The gate counter width is derived from `GATE_CYCLES` (clog2).

## Test plan
All scenarios except 1 use `GATE_CYCLES` = 1000 and `CNT_W` = 27 unless stated.
1. Assert `Rst` with `sig_in` toggling, then release → `freq` = 0, `valid` = 0, `busy` = 0, `ovf` = 0; no `valid` without `start` or `cont`.
2. `sig_in` period 10 cycles, already running; one `start` pulse → exactly one `valid`, 1001 cycles after `start`. `freq` = 100 (phase-aligned stimulus) and ±1 over randomized phase. `ovf` = 0.
3. `cont` = 1 held, `sig_in` period 20 → `valid` pulses every 1001 cycles with `freq` = 50. Drop `cont` mid-window → that window latches, then `busy` falls and IDLE is held.
4. `CNT_W` = 4, `sig_in` period 10 → `freq` = 15, `ovf` = 1. The next window with `sig_in` held low → `freq` = 0, `ovf` = 0.
5. Extra `start` pulses during GATE are ignored: one `valid` only. Assert `Rst` at gate cycle 500 → no `valid`, all outputs 0 immediately.
6. `sig_in` constant high or constant low (after sync settles) → `freq` = 0. `sig_in` high/low 1 cycle each → count < true rate; the bench records it as aliasing and checks only that there is no hang.
